if_stage_ifid: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of ID and the hazard unit.

---
 rtl/if_stage_ifid.sv | 114 +++++++++++
 tb/tb_if_stage_ifid.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/if_stage_ifid.sv
// Instruction fetch stage and IF/ID pipeline register with a 1-entry hold buffer.
// Optional perf counters (stall/flush/wait) enabled by defining IFID_PERF_CNT_EN.
module if_stage_ifid #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          PERF_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              PCWrite_i,
  input  logic              IFIDStall_i,
  input  logic              IFIDFlush_i,
  input  logic [31:0]       branch_target_i,
  output logic              imem_req_o,
  output logic [31:0]       imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       pc_IFID_o,
  output logic [31:0]       instr_IFID_o,
  output logic              valid_IFID_o,
`ifdef IFID_PERF_CNT_EN
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o,
  output logic [PERF_W-1:0] wait_cnt_o,
`endif
  output logic              fetch_busy_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        advance;
  logic        xfer;

  assign advance      = PCWrite_i & ~IFIDStall_i;
  assign imem_req_o   = (state == FETCH);
  assign imem_addr_o  = pc;
  assign xfer         = imem_req_o & imem_ready_i;
  assign fetch_busy_o = imem_req_o & ~imem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      hold_pc      <= RESET_PC;
      hold_instr   <= NOP_INSTR;
      pc_IFID_o    <= RESET_PC;
      instr_IFID_o <= NOP_INSTR;
      valid_IFID_o <= 1'b0;
    end else if (IFIDFlush_i) begin
      // Redirect wins; any beat arriving this cycle belongs to the wrong path.
      state        <= FETCH;
      pc           <= branch_target_i;
      pc_IFID_o    <= branch_target_i;
      instr_IFID_o <= NOP_INSTR;
      valid_IFID_o <= 1'b0;
    end else begin
      unique case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (xfer && advance) begin
            pc_IFID_o    <= pc;
            instr_IFID_o <= imem_rdata_i;
            valid_IFID_o <= 1'b1;
            pc           <= pc + 32'd4;
          end else if (xfer) begin
            hold_pc    <= pc;
            hold_instr <= imem_rdata_i;
            state      <= HOLD;
          end else if (!IFIDStall_i) begin
            pc_IFID_o    <= pc;
            instr_IFID_o <= NOP_INSTR;
            valid_IFID_o <= 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            pc_IFID_o    <= hold_pc;
            instr_IFID_o <= hold_instr;
            valid_IFID_o <= 1'b1;
            pc           <= pc + 32'd4;
            state        <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      wait_cnt_o  <= '0;
    end else begin
      if (IFIDStall_i && !IFIDFlush_i && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (IFIDFlush_i && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + 1'b1;
      if (fetch_busy_o && wait_cnt_o != '1)
        wait_cnt_o <= wait_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_ifid.sv
// Directed bench for if_stage_ifid: expected IF/ID entries queued per step.
// Perf counter checks compile only with IFID_PERF_CNT_EN.
module tb_if_stage_ifid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
  } ifid_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pcw, stl, fls, rdy;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr, rdata;
  logic [31:0] pc_o, instr_o;
  logic        valid_o, busy;
`ifdef IFID_PERF_CNT_EN
  logic [1:0]  scnt, fcnt, wcnt;
`endif

  int total = 0;
  int bad   = 0;
  ifid_t q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign rdata = mem(addr);

  if_stage_ifid #(
`ifdef IFID_PERF_CNT_EN
    .PERF_W(2)
`else
    .PERF_W(32)
`endif
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .PCWrite_i(pcw),
    .IFIDStall_i(stl),
    .IFIDFlush_i(fls),
    .branch_target_i(tgt),
    .imem_req_o(req),
    .imem_addr_o(addr),
    .imem_ready_i(rdy),
    .imem_rdata_i(rdata),
    .pc_IFID_o(pc_o),
    .instr_IFID_o(instr_o),
    .valid_IFID_o(valid_o),
`ifdef IFID_PERF_CNT_EN
    .stall_cnt_o(scnt),
    .flush_cnt_o(fcnt),
    .wait_cnt_o(wcnt),
`endif
    .fetch_busy_o(busy)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check decoded outputs, queue the IF/ID result for after the edge.
  task automatic step(
    input string       tag,
    input logic        r, w, s, f, y,
    input logic [31:0] t,
    input logic        cc, ereq, ebusy,
    input logic [31:0] eaddr, epc, einstr,
    input logic        ev
  );
    ifid_t e;
    rst = r; pcw = w; stl = s; fls = f; rdy = y; tgt = t;
    #1;
    if (cc) begin
      chk({tag, ".req"}, 65'(req), 65'(ereq));
      chk({tag, ".busy"}, 65'(busy), 65'(ebusy));
      if (ereq) chk({tag, ".addr"}, 65'(addr), 65'(eaddr));
    end
    q.push_back('{epc, einstr, ev});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".ifid"}, {pc_o, instr_o, valid_o}, e);
  endtask

  initial begin
    rst = 1'b1; pcw = 1'b1; stl = 1'b0; fls = 1'b0; rdy = 1'b1; tgt = '0;
    // T1
    step("rst0", 1,1,0,0,1, 0, 0,0,0, 0, 0, NOP, 0);
    step("rst1", 1,1,0,0,1, 0, 1,0,0, 0, 0, NOP, 0);
    step("boot", 0,1,0,0,1, 0, 1,0,0, 0, 0, NOP, 0);
    step("f0",   0,1,0,0,1, 0, 1,1,0, 0, 0, mem(0), 1);
    step("f4",   0,1,0,0,1, 0, 1,1,0, 4, 4, mem(4), 1);
    // T2
    for (int i = 0; i < 3; i++)
      step("wait8", 0,1,0,0,0, 0, 1,1,1, 8, 8, NOP, 0);
    step("f8",   0,1,0,0,1, 0, 1,1,0, 8, 8, mem(8), 1);
    // T3
    step("holdC", 0,0,1,0,1, 0, 1,1,0, 32'hC, 8, mem(8), 1);
    step("inhold",0,0,1,0,1, 0, 1,0,0, 0, 8, mem(8), 1);
    step("relC",  0,1,0,0,0, 0, 1,0,0, 0, 32'hC, mem(32'hC), 1);
    step("stlnx", 0,1,1,0,0, 0, 1,1,1, 32'h10, 32'hC, mem(32'hC), 1);
    step("pcw0",  0,0,0,0,1, 0, 1,1,0, 32'h10, 32'hC, mem(32'hC), 1);
    // T4
    step("flhold",0,1,1,1,1, 32'h100, 1,0,0, 0, 32'h100, NOP, 0);
    step("f100",  0,1,0,0,1, 0, 1,1,0, 32'h100, 32'h100, mem(32'h100), 1);
    step("flxfer",0,1,0,1,1, 32'hFFFF_FFFC, 1,1,0, 32'h104, 32'hFFFF_FFFC, NOP, 0);
    // T5
    step("fwrap", 0,1,0,0,1, 0, 1,1,0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1);
    step("f0b",   0,1,0,0,1, 0, 1,1,0, 0, 0, mem(0), 1);
    step("hold4", 0,0,1,0,1, 0, 1,1,0, 4, 0, mem(0), 1);
    step("rsthld",1,0,1,0,1, 0, 1,0,0, 0, 0, NOP, 0);
    step("boot2", 0,1,0,0,1, 0, 1,0,0, 0, 0, NOP, 0);
    step("flodd", 0,1,0,1,0, 32'h203, 1,1,1, 0, 32'h203, NOP, 0);
    step("f203",  0,1,0,0,1, 0, 1,1,0, 32'h203, 32'h203, mem(32'h203), 1);
`ifdef IFID_PERF_CNT_EN
    // T6
    step("prst",  1,1,0,0,1, 0, 0,0,0, 0, 0, NOP, 0);
    chk("cnt0", 65'({scnt, fcnt, wcnt}), 65'(6'b0));
    step("pboot", 0,1,0,0,0, 0, 1,0,0, 0, 0, NOP, 0);
    for (int i = 0; i < 3; i++)
      step("pwait", 0,1,0,0,0, 0, 1,1,1, 0, 0, NOP, 0);
    step("pstl1", 0,0,1,0,1, 0, 1,1,0, 0, 0, NOP, 0);
    step("pstl2", 0,0,1,0,1, 0, 1,0,0, 0, 0, NOP, 0);
    step("pfl",   0,1,1,1,0, 32'h40, 1,0,0, 0, 32'h40, NOP, 0);
    chk("stall", 65'(scnt), 65'(2'd2));
    chk("flush", 65'(fcnt), 65'(2'd1));
    chk("wait",  65'(wcnt), 65'(2'd3));
    step("psat",  0,1,0,0,0, 0, 1,1,1, 32'h40, 32'h40, NOP, 0);
    chk("waitsat", 65'(wcnt), 65'(2'd3));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
